// File: rtl/poly_song_sequencer.sv
// poly_song_sequencer
// Walks one song of a multi-song ROM and dispatches note/duration pairs to
// NUM_VOICES note players. It supports 1x/2x/4x/8x speed, forward or backward
// play with a live direction flip, loop mode and pause.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   play       1 = run, 0 = pause (position and state are held)
//   song       song select; a change while running aborts to IDLE
//   beat       one-cycle beat tick that clocks the wait counter
//   backwards  walk indices downward
//   speed      right shift applied to durations and waits
//   loop       restart the song at its end instead of finishing
//   rom_addr   registered ROM address {song, index}
//   rom_data   synchronous ROM word, valid one cycle after rom_addr
//   note_bus   per-voice note slots, voice v at [v*NOTE_W +: NOTE_W]
//   dur_bus    per-voice scaled durations, voice v at [v*DUR_W +: DUR_W]
//   load_note  one-cycle load strobe per voice
//   song_done  one-cycle pulse when a non-looping song ends
module poly_song_sequencer #(
    parameter int NUM_VOICES = 3,
    parameter int NUM_SONGS  = 4,
    parameter int SONG_LEN   = 32,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int VSEL_W     = 2,
    localparam int SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int IDX_W     = $clog2(SONG_LEN),
    localparam int ADDR_W    = SONG_W + IDX_W,
    localparam int WORD_W    = 1 + VSEL_W + NOTE_W + DUR_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         play,
    input  logic [SONG_W-1:0]            song,
    input  logic                         beat,
    input  logic                         backwards,
    input  logic [1:0]                   speed,
    input  logic                         loop,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [WORD_W-1:0]            rom_data,
    output logic [NUM_VOICES*NOTE_W-1:0] note_bus,
    output logic [NUM_VOICES*DUR_W-1:0]  dur_bus,
    output logic [NUM_VOICES-1:0]        load_note,
    output logic                         song_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ROMWAIT = 3'd2,
        ST_DECODE  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t              state_r;
    logic [SONG_W-1:0]   song_l_r;
    logic [IDX_W-1:0]    idx_r;
    logic [DUR_W-1:0]    cnt_r;

    logic                w_is_wait_s;
    logic [VSEL_W-1:0]   w_voice_s;
    logic [NOTE_W-1:0]   w_note_s;
    logic [DUR_W-1:0]    w_dur_s;
    logic [DUR_W-1:0]    scaled_s;
    logic [IDX_W-1:0]    start_idx_s;
    logic [IDX_W-1:0]    adv_idx_s;
    state_t              adv_state_s;
    logic                adv_done_s;

    // Speed scaling: a non-zero duration never collapses to zero.
    function automatic logic [DUR_W-1:0] scale_dur(input logic [DUR_W-1:0] d,
                                                   input logic [1:0]       sp);
        logic [DUR_W-1:0] s;
        s = d >> sp;
        if ((d != DUR_W'(0)) && (s == DUR_W'(0))) begin
            s = DUR_W'(1);
        end else begin
            s = s;
        end
        return s;
    endfunction

    // Split the ROM word into its fields and scale its duration.
    always_comb begin
        w_is_wait_s = rom_data[WORD_W-1];
        w_voice_s   = rom_data[NOTE_W+DUR_W +: VSEL_W];
        w_note_s    = rom_data[DUR_W +: NOTE_W];
        w_dur_s     = rom_data[DUR_W-1:0];
        scaled_s    = scale_dur(w_dur_s, speed);
    end

    // Next position after the current word; direction is sampled live so a
    // flip reverses from wherever the walk currently is.
    always_comb begin
        adv_idx_s   = idx_r;
        adv_state_s = ST_FETCH;
        adv_done_s  = 1'b0;
        start_idx_s = backwards ? IDX_W'(SONG_LEN - 1) : IDX_W'(0);
        if (backwards ? (idx_r == IDX_W'(0)) : (idx_r == IDX_W'(SONG_LEN - 1))) begin
            if (loop) begin
                adv_idx_s   = start_idx_s;
                adv_state_s = ST_FETCH;
                adv_done_s  = 1'b0;
            end else begin
                adv_idx_s   = idx_r;
                adv_state_s = ST_DONE;
                adv_done_s  = 1'b1;
            end
        end else begin
            adv_idx_s   = backwards ? (idx_r - IDX_W'(1)) : (idx_r + IDX_W'(1));
            adv_state_s = ST_FETCH;
            adv_done_s  = 1'b0;
        end
    end

    // Sequencer FSM with registered ROM address, voice slots and strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            song_l_r  <= '0;
            idx_r     <= '0;
            cnt_r     <= '0;
            rom_addr  <= '0;
            note_bus  <= '0;
            dur_bus   <= '0;
            load_note <= '0;
            song_done <= 1'b0;
        end else begin
            load_note <= '0;
            song_done <= 1'b0;
            // A song change abandons the current run silently.
            if ((state_r != ST_IDLE) && (song != song_l_r)) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (play) begin
                            song_l_r <= song;
                            idx_r    <= start_idx_s;
                            state_r  <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        // Pause holds here, between words.
                        if (play) begin
                            rom_addr <= {song_l_r, idx_r};
                            state_r  <= ST_ROMWAIT;
                        end
                    end
                    ST_ROMWAIT: begin
                        state_r <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        if (w_is_wait_s && (scaled_s != DUR_W'(0))) begin
                            cnt_r   <= scaled_s;
                            state_r <= ST_WAIT;
                        end else begin
                            if (!w_is_wait_s) begin
                                // Out-of-range voice numbers match no slot.
                                for (int v = 0; v < NUM_VOICES; v++) begin
                                    if (w_voice_s == VSEL_W'(v)) begin
                                        load_note[v]                  <= 1'b1;
                                        note_bus[v*NOTE_W +: NOTE_W]  <= w_note_s;
                                        dur_bus[v*DUR_W +: DUR_W]     <= scaled_s;
                                    end
                                end
                            end
                            cnt_r     <= '0;
                            idx_r     <= adv_idx_s;
                            state_r   <= adv_state_s;
                            song_done <= adv_done_s;
                        end
                    end
                    ST_WAIT: begin
                        if (beat && play) begin
                            if (cnt_r <= DUR_W'(1)) begin
                                cnt_r     <= '0;
                                idx_r     <= adv_idx_s;
                                state_r   <= adv_state_s;
                                song_done <= adv_done_s;
                            end else begin
                                cnt_r <= cnt_r - DUR_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_poly_song_sequencer.sv
module tb_poly_song_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play = 1'b0;
    logic [1:0]  song = 2'd0;
    logic        man_beat = 1'b0;
    logic        auto_pulse = 1'b0;
    logic        auto_en = 1'b0;
    logic [1:0]  acnt = 2'd0;
    logic        beat;
    logic        backwards = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        loop = 1'b0;
    logic [6:0]  rom_addr;
    logic [14:0] rom_data = 15'd0;
    logic [17:0] note_bus;
    logic [17:0] dur_bus;
    logic [2:0]  load_note;
    logic        song_done;

    logic [14:0] rom [0:127];

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int cnt31 = 0;
    logic [2:0] last_load = 3'd0;
    logic [5:0] last_note = 6'd0;
    logic [5:0] note_at_done = 6'd0;

    assign beat = man_beat | auto_pulse;

    poly_song_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .play      (play),
        .song      (song),
        .beat      (beat),
        .backwards (backwards),
        .speed     (speed),
        .loop      (loop),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_bus  (note_bus),
        .dur_bus   (dur_bus),
        .load_note (load_note),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    // synchronous ROM model
    always @(posedge clk) rom_data <= rom[rom_addr];

    // free-running beat, one tick every 4 cycles
    always @(negedge clk) begin
        if (auto_en) begin
            acnt       <= acnt + 2'd1;
            auto_pulse <= (acnt == 2'd0);
        end else begin
            acnt       <= 2'd0;
            auto_pulse <= 1'b0;
        end
    end

    // strobe / done monitor, sampled 2 time units after the active edge
    always begin
        @(posedge clk);
        #2;
        if (reset_n) begin
            if (load_note != 3'd0) begin
                strobe_cnt++;
                last_load = load_note;
                for (int v = 0; v < 3; v++) begin
                    if (load_note[v]) last_note = note_bus[v*6 +: 6];
                end
                if (load_note[0] && note_bus[5:0] == 6'd31) cnt31++;
                checks++;
                if ($countones(load_note) != 1) begin
                    failures++;
                    $display("FAIL onehot actual=%b required=one bit set", load_note);
                end
            end
            if (song_done) begin
                done_cnt++;
                note_at_done = last_note;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    function automatic logic [14:0] mkw(input logic w, input logic [1:0] v,
                                        input logic [5:0] n, input logic [5:0] d);
        return {w, v, n, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        play    = 1'b0;
        man_beat = 1'b0;
        auto_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_beat();
        @(negedge clk);
        man_beat = 1'b1;
        @(negedge clk);
        man_beat = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_strobe(input int budget, output logic ok);
        int s;
        s  = strobe_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (strobe_cnt != s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  sp;
        logic [1:0]  v;
        logic [5:0]  n;
        logic [5:0]  d;
        logic [2:0]  eload;
        logic [17:0] enote;
        logic [17:0] edur;
    } vec_t;

    vec_t tv [8];
    int   exp_beats [4];
    int   exp_dur8 [4];

    initial begin
        logic ok;
        int   s;
        int   d;
        int   c;

        // ROM: idx k plays note k on voice 0 unless overridden
        for (int i = 0; i < 128; i++) rom[i] = mkw(1'b0, 2'd0, 6'(i % 32), 6'(i % 32));
        rom[0]  = mkw(1'b0, 2'd0, 6'd10, 6'd8);
        rom[1]  = mkw(1'b1, 2'd0, 6'd0,  6'd4);
        rom[2]  = mkw(1'b0, 2'd1, 6'd20, 6'd8);
        rom[3]  = mkw(1'b1, 2'd0, 6'd0,  6'd10);
        rom[33] = mkw(1'b1, 2'd0, 6'd0,  6'd63);
        rom[64] = mkw(1'b0, 2'd2, 6'd42, 6'd5);

        tv[0] = '{2'd0, 2'd0, 6'd10, 6'd8,  3'b001, 18'd10,     18'd8};
        tv[1] = '{2'd1, 2'd0, 6'd10, 6'd8,  3'b001, 18'd10,     18'd4};
        tv[2] = '{2'd3, 2'd1, 6'd20, 6'd8,  3'b010, 18'd1280,   18'd64};
        tv[3] = '{2'd3, 2'd2, 6'd5,  6'd1,  3'b100, 18'd20480,  18'd4096};
        tv[4] = '{2'd2, 2'd2, 6'd63, 6'd0,  3'b100, 18'd258048, 18'd0};
        tv[5] = '{2'd0, 2'd3, 6'd7,  6'd9,  3'b000, 18'd0,      18'd0};
        tv[6] = '{2'd2, 2'd1, 6'd33, 6'd63, 3'b010, 18'd2112,   18'd960};
        tv[7] = '{2'd1, 2'd0, 6'd1,  6'd3,  3'b001, 18'd1,      18'd1};
        exp_beats = '{4, 2, 1, 1};
        exp_dur8  = '{8, 4, 2, 1};

        // reset state
        do_reset();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_note_bus", 32'(note_bus), 32'd0);
        chk("rst_dur_bus", 32'(dur_bus), 32'd0);
        chk("rst_load", 32'(load_note), 32'd0);
        chk("rst_done", 32'(song_done), 32'd0);

        // single-word decode vectors on song 1
        for (int k = 0; k < 8; k++) begin
            rom[32] = mkw(1'b0, tv[k].v, tv[k].n, tv[k].d);
            song  = 2'd1;
            speed = tv[k].sp;
            do_reset();
            s = strobe_cnt;
            play = 1'b1;
            wait_cycles(8);
            play = 1'b0;
            chk($sformatf("vec%0d_strobes", k), 32'(strobe_cnt - s), (tv[k].eload != 3'd0) ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_load", k), (strobe_cnt != s) ? 32'(last_load) : 32'd0, 32'(tv[k].eload));
            chk($sformatf("vec%0d_note", k), 32'(note_bus), 32'(tv[k].enote));
            chk($sformatf("vec%0d_dur", k), 32'(dur_bus), 32'(tv[k].edur));
        end

        // forward play at each speed: wait of 4 beats and dur 8 scaled
        for (int sp = 0; sp < 4; sp++) begin
            song = 2'd0; speed = 2'(sp); backwards = 1'b0; loop = 1'b0;
            do_reset();
            play = 1'b1;
            wait_strobe(10, ok);
            chk($sformatf("sp%0d_first_seen", sp), 32'(ok), 32'd1);
            chk($sformatf("sp%0d_first_load", sp), 32'(last_load), 32'd1);
            chk($sformatf("sp%0d_first_note", sp), 32'(note_bus[5:0]), 32'd10);
            chk($sformatf("sp%0d_first_dur", sp), 32'(dur_bus[5:0]), 32'(exp_dur8[sp]));
            wait_cycles(5);
            s = strobe_cnt;
            repeat (exp_beats[sp] - 1) pulse_beat();
            wait_cycles(4);
            chk($sformatf("sp%0d_early", sp), 32'(strobe_cnt - s), 32'd0);
            pulse_beat();
            wait_cycles(3);
            chk($sformatf("sp%0d_second_cnt", sp), 32'(strobe_cnt - s), 32'd1);
            chk($sformatf("sp%0d_second_load", sp), 32'(last_load), 32'd2);
            chk($sformatf("sp%0d_second_note", sp), 32'(note_bus[11:6]), 32'd20);
            chk($sformatf("sp%0d_second_dur", sp), 32'(dur_bus[11:6]), 32'(exp_dur8[sp]));
        end

        // pause during WAIT: beats ignored, remaining beats honoured on resume
        song = 2'd0; speed = 2'd0;
        do_reset();
        play = 1'b1;
        wait_strobe(10, ok);
        wait_cycles(5);
        s = strobe_cnt;
        pulse_beat();
        play = 1'b0;
        repeat (5) pulse_beat();
        wait_cycles(3);
        chk("pause_no_strobe", 32'(strobe_cnt - s), 32'd0);
        play = 1'b1;
        repeat (2) pulse_beat();
        wait_cycles(4);
        chk("resume_early", 32'(strobe_cnt - s), 32'd0);
        pulse_beat();
        wait_cycles(3);
        chk("resume_strobe", 32'(strobe_cnt - s), 32'd1);
        chk("resume_load", 32'(last_load), 32'd2);

        // song switch 0 -> 2 mid-song
        do_reset();
        play = 1'b1;
        wait_strobe(10, ok);
        wait_cycles(5);
        chk("pre_switch_addr", 32'(rom_addr), 32'd1);
        s = strobe_cnt;
        d = done_cnt;
        song = 2'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rom_addr != 7'd1) break;
        end
        chk("switch_addr", 32'(rom_addr), 32'd64);
        chk("switch_no_strobe", 32'(strobe_cnt - s), 32'd0);
        chk("switch_no_done", 32'(done_cnt - d), 32'd0);
        wait_strobe(10, ok);
        chk("switch_load", 32'(last_load), 32'd4);
        chk("switch_note", 32'(note_bus[17:12]), 32'd42);

        // asynchronous reset while in WAIT
        song = 2'd0;
        do_reset();
        play = 1'b1;
        wait_strobe(10, ok);
        wait_cycles(5);
        chk("pre_areset_note", 32'(note_bus), 32'd10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_addr", 32'(rom_addr), 32'd0);
        chk("areset_note", 32'(note_bus), 32'd0);
        chk("areset_dur", 32'(dur_bus), 32'd0);
        chk("areset_load", 32'(load_note), 32'd0);
        chk("areset_done", 32'(song_done), 32'd0);

        // backwards, non-looping: starts at 31, done after index 0, restarts
        backwards = 1'b1; loop = 1'b0;
        do_reset();
        auto_en = 1'b1;
        play = 1'b1;
        wait_strobe(10, ok);
        chk("bwd_first_load", 32'(last_load), 32'd1);
        chk("bwd_first_note", 32'(note_bus[5:0]), 32'd31);
        chk("bwd_first_dur", 32'(dur_bus[5:0]), 32'd31);
        d = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done_cnt != d) break;
        end
        chk("bwd_done_seen", 32'(done_cnt - d), 32'd1);
        chk("bwd_last_note", 32'(note_at_done), 32'd10);
        wait_strobe(10, ok);
        chk("bwd_restart_note", 32'(last_note), 32'd31);

        // backwards, looping: restarts at 31 without song_done
        loop = 1'b1;
        do_reset();
        c = cnt31;
        d = done_cnt;
        auto_en = 1'b1;
        play = 1'b1;
        wait_cycles(500);
        chk("loop_restarts", 32'((cnt31 - c) >= 2), 32'd1);
        chk("loop_no_done", 32'(done_cnt - d), 32'd0);
        play = 1'b0;
        auto_en = 1'b0;
        wait_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
